// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of every request, response and memory-bus signal
// that passes through the memory arbiter.
//
// Handshake rules:
//   - A requester raises *_req_valid and holds it, and its address, command and
//     data, until it sees *_req_grant. A fetch request may also be withdrawn by
//     if_squash. The grant is combinational and occurs in the same cycle that
//     memory accepts the request. Memory accepts by returning a nonzero
//     mem2proc_response tag.
//   - Responses (*_resp_valid) are single-cycle pulses and have no back-pressure.
//
// Modports:
//   slave  : the arbiter side. It takes requests and memory returns, and drives
//            the grants, the responses, the proc2mem bus and outstanding.
//   master : the environment side, which holds the requesters and the memory.
`ifndef XLEN
`define XLEN 32
`endif

interface mem_arbiter_if;
  // fetch port
  logic              if_req_valid;
  logic [`XLEN-1:0]  if_req_addr;
  logic              if_squash;
  logic              if_req_grant;
  logic              if_resp_valid;
  logic [63:0]       if_resp_data;
  // data port
  logic              d_req_valid;
  logic [1:0]        d_req_cmd;
  logic [`XLEN-1:0]  d_req_addr;
  logic [63:0]       d_req_data;
  logic              d_req_grant;
  logic              d_resp_valid;
  logic [63:0]       d_resp_data;
  // memory bus
  logic [1:0]        proc2mem_command;
  logic [`XLEN-1:0]  proc2mem_addr;
  logic [63:0]       proc2mem_data;
  logic [3:0]        mem2proc_response;
  logic [63:0]       mem2proc_data;
  logic [3:0]        mem2proc_tag;
  // status
  logic [4:0]        outstanding;

  modport slave (
    input  if_req_valid, if_req_addr, if_squash,
    input  d_req_valid, d_req_cmd, d_req_addr, d_req_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output if_req_grant, if_resp_valid, if_resp_data,
    output d_req_grant, d_resp_valid, d_resp_data,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    output outstanding
  );

  modport master (
    output if_req_valid, if_req_addr, if_squash,
    output d_req_valid, d_req_cmd, d_req_addr, d_req_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  if_req_grant, if_resp_valid, if_resp_data,
    input  d_req_grant, d_resp_valid, d_resp_data,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    input  outstanding
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one tagged memory port between an instruction-fetch
// requester and a data requester.
//
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-high. It clears the tag table, the starvation
//            counter and outstanding, and forces the bus idle.
//   bus    : mem_arbiter_if.slave. Holds the fetch and data requests, the
//            grants, the responses, the proc2mem/mem2proc bus and outstanding.
//
// Parameter:
//   STARVE_LIMIT : the number of consecutive data grants allowed while a fetch
//                  request waits. After that many, fetch wins.
//
// Selection and the grants are combinational. Data wins over fetch unless the
// starvation counter has reached STARVE_LIMIT. Fetch is never selected while
// if_squash=1. Each accepted load records its owner in a 16-entry tag table
// indexed by the memory tag. Tag 0 means "none" and is never allocated. A
// returning tag is routed to its owner in the same cycle, unless a squash has
// marked the entry as discard.
`ifndef XLEN
`define XLEN 32
`endif

module mem_arbiter #(
  parameter int STARVE_LIMIT = 2
) (
  input  logic            clock,
  input  logic            reset,
  mem_arbiter_if.slave    bus
);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  // One extra bit keeps the saturating compare free of wrap-around.
  localparam int SW = $clog2(STARVE_LIMIT + 1) + 1;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  // Tag table, one bit per tag in each vector. Owner is 0 for fetch and
  // 1 for data.
  logic [15:0]   ent_valid;
  logic [15:0]   ent_owner;
  logic [15:0]   ent_discard;

  logic [SW-1:0] starve_cnt;
  logic [4:0]    outstanding_q;

  logic          fetch_ok;
  logic          fetch_first;
  logic          sel_fetch;
  logic          sel_data;
  logic          accepted;
  logic          if_grant;
  logic          d_grant;
  logic          alloc;
  logic          alloc_owner;
  logic          ret_hit;
  logic          ret_owner;
  logic          ret_discard;
  logic          inc;
  logic          dec;

  // ---------------------------------------------------------------------------
  // Requester selection
  // ---------------------------------------------------------------------------
  assign fetch_ok    = bus.if_req_valid && !bus.if_squash;
  assign fetch_first = (starve_cnt >= LIMIT);

  always_comb begin
    sel_fetch = 1'b0;
    sel_data  = 1'b0;
    if (!reset) begin
      if (fetch_ok && (fetch_first || !bus.d_req_valid)) begin
        sel_fetch = 1'b1;
      end else if (bus.d_req_valid) begin
        sel_data = 1'b1;
      end
    end
  end

  // The selected requester is driven every cycle, even while memory refuses
  // the request, so the bus shows the retry.
  always_comb begin
    bus.proc2mem_command = BUS_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    if (sel_fetch) begin
      bus.proc2mem_command = BUS_LOAD;
      bus.proc2mem_addr    = bus.if_req_addr;
    end else if (sel_data) begin
      bus.proc2mem_command = bus.d_req_cmd;
      bus.proc2mem_addr    = bus.d_req_addr;
      bus.proc2mem_data    = bus.d_req_data;
    end
  end

  assign accepted = (bus.mem2proc_response != 4'd0);
  assign if_grant = sel_fetch && accepted;
  assign d_grant  = sel_data && accepted;

  assign bus.if_req_grant = if_grant;
  assign bus.d_req_grant  = d_grant;

  // Stores complete on acceptance. Only loads take a table entry.
  assign alloc       = if_grant || (d_grant && (bus.d_req_cmd == BUS_LOAD));
  assign alloc_owner = d_grant;

  // ---------------------------------------------------------------------------
  // Return path
  // ---------------------------------------------------------------------------
  // The table is read before any update from this cycle. A squash in the same
  // cycle therefore cannot suppress a fetch return that is already arriving.
  assign ret_hit     = !reset && (bus.mem2proc_tag != 4'd0) && ent_valid[bus.mem2proc_tag];
  assign ret_owner   = ent_owner[bus.mem2proc_tag];
  assign ret_discard = ent_discard[bus.mem2proc_tag];

  assign bus.if_resp_valid = ret_hit && !ret_owner && !ret_discard;
  assign bus.d_resp_valid  = ret_hit &&  ret_owner && !ret_discard;
  assign bus.if_resp_data  = bus.mem2proc_data;
  assign bus.d_resp_data   = bus.mem2proc_data;

  // outstanding follows the number of valid entries. An allocation only adds
  // one if its slot is free or is being freed in the same cycle.
  assign dec = ret_hit;
  assign inc = alloc &&
               (!ent_valid[bus.mem2proc_response] ||
                (ret_hit && (bus.mem2proc_tag == bus.mem2proc_response)));

  assign bus.outstanding = outstanding_q;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      ent_valid     <= '0;
      ent_owner     <= '0;
      ent_discard   <= '0;
      starve_cnt    <= '0;
      outstanding_q <= '0;
    end else begin
      // Later assignments win: squash, then free, then allocate. A tag that
      // returns and is reallocated in the same cycle ends up valid with its
      // new owner.
      if (bus.if_squash) begin
        ent_discard <= ent_discard | (ent_valid & ~ent_owner);
      end
      if (ret_hit) begin
        ent_valid[bus.mem2proc_tag] <= 1'b0;
      end
      if (alloc) begin
        ent_valid[bus.mem2proc_response]   <= 1'b1;
        ent_owner[bus.mem2proc_response]   <= alloc_owner;
        ent_discard[bus.mem2proc_response] <= 1'b0;
      end

      outstanding_q <= outstanding_q + 5'(inc) - 5'(dec);

      if (!bus.if_req_valid || if_grant) begin
        starve_cnt <= '0;
      end else if (d_grant && (starve_cnt < LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed bench for mem_arbiter with STARVE_LIMIT=2.
// The main process drives the requesters and the memory side. It checks the
// grants and the bus at the falling edge, and it pushes every response it
// expects into exp_q as {owner, data}, where owner is 1 for data and 0 for
// fetch. A separate monitor pops exp_q whenever a response appears.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_arbiter;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [64:0] exp_q[$];

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.if_req_valid      = 1'b0;
    bus.if_req_addr       = '0;
    bus.if_squash         = 1'b0;
    bus.d_req_valid       = 1'b0;
    bus.d_req_cmd         = 2'd0;
    bus.d_req_addr        = '0;
    bus.d_req_data        = '0;
    bus.mem2proc_response = 4'd0;
    bus.mem2proc_data     = '0;
    bus.mem2proc_tag      = 4'd0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mem_return(input logic [3:0] tag, input logic [63:0] data);
    bus.mem2proc_tag  = tag;
    bus.mem2proc_data = data;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.if_resp_valid && bus.d_resp_valid) begin
        n_checks++;
        n_fail++;
        $display("FAIL both_resp: got both valids expected at most one");
      end else if (bus.if_resp_valid || bus.d_resp_valid) begin
        logic [64:0] got;
        got = {bus.d_resp_valid, bus.d_resp_valid ? bus.d_resp_data : bus.if_resp_data};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_resp: got %0h expected none", got);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL resp: got %0h expected %0h", got, e);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [5:0] GRANT_PAT = 6'b011011;  // bit i=1: data granted in cycle i

  initial begin
    clear_inputs();
    reset = 1'b1;
    // Requests and returns held during reset must have no effect.
    bus.if_req_valid = 1'b1;
    bus.d_req_valid = 1'b1;
    bus.d_req_cmd = 2'd1;
    bus.mem2proc_response = 4'd3;
    bus.mem2proc_tag = 4'd3;
    tick(); tick();
    @(negedge clock);
    check("rst_command", 64'(bus.proc2mem_command), 64'd0);
    check("rst_if_grant", 64'(bus.if_req_grant), 64'd0);
    check("rst_d_grant", 64'(bus.d_req_grant), 64'd0);
    check("rst_resp", 64'({bus.if_resp_valid, bus.d_resp_valid}), 64'd0);
    check("rst_outstanding", 64'(bus.outstanding), 64'd0);
    tick();
    reset = 1'b0;
    clear_inputs();
    tick();

    // Both requesters load with response 3, so data wins.
    bus.if_req_valid = 1'b1; bus.if_req_addr = 'h100;
    bus.d_req_valid = 1'b1; bus.d_req_cmd = 2'd1; bus.d_req_addr = 'h2008;
    bus.mem2proc_response = 4'd3;
    @(negedge clock);
    check("both_d_grant", 64'(bus.d_req_grant), 64'd1);
    check("both_if_grant", 64'(bus.if_req_grant), 64'd0);
    check("both_command", 64'(bus.proc2mem_command), 64'd1);
    check("both_addr", 64'(bus.proc2mem_addr), 64'h2008);
    tick();
    clear_inputs();
    mem_return(4'd3, 64'hA5A5_0000_1111_0003);
    exp_q.push_back({1'b1, 64'hA5A5_0000_1111_0003});
    @(negedge clock);
    check("both_outstanding", 64'(bus.outstanding), 64'd1);
    tick();
    clear_inputs();
    @(negedge clock);
    check("both_outstanding_free", 64'(bus.outstanding), 64'd0);
    tick();

    // Starvation: grant order is data, data, fetch, data, data, fetch.
    for (int i = 0; i < 6; i++) begin
      bus.if_req_valid = 1'b1; bus.if_req_addr = 'h800;
      bus.d_req_valid = 1'b1; bus.d_req_cmd = 2'd1; bus.d_req_addr = 'h900;
      bus.mem2proc_response = 4'(i + 1);
      @(negedge clock);
      check($sformatf("starve_d_grant_%0d", i), 64'(bus.d_req_grant), 64'(GRANT_PAT[i]));
      check($sformatf("starve_if_grant_%0d", i), 64'(bus.if_req_grant), 64'(!GRANT_PAT[i]));
      check($sformatf("starve_addr_%0d", i), 64'(bus.proc2mem_addr),
            GRANT_PAT[i] ? 64'h900 : 64'h800);
      tick();
    end
    clear_inputs();
    @(negedge clock);
    check("starve_outstanding", 64'(bus.outstanding), 64'd6);
    tick();
    for (int i = 0; i < 6; i++) begin
      mem_return(4'(i + 1), 64'h1000 + 64'(i));
      exp_q.push_back({GRANT_PAT[i], 64'h1000 + 64'(i)});
      tick();
    end
    clear_inputs();
    @(negedge clock);
    check("starve_outstanding_free", 64'(bus.outstanding), 64'd0);
    tick();

    // Fetch granted with tag 5, squashed, then tag 5 returns and is dropped.
    bus.if_req_valid = 1'b1; bus.if_req_addr = 'h300;
    bus.mem2proc_response = 4'd5;
    @(negedge clock);
    check("sq_if_grant", 64'(bus.if_req_grant), 64'd1);
    check("sq_addr", 64'(bus.proc2mem_addr), 64'h300);
    tick();
    bus.if_squash = 1'b1;
    bus.mem2proc_response = 4'd6;
    @(negedge clock);
    check("sq_no_grant", 64'(bus.if_req_grant), 64'd0);
    check("sq_command", 64'(bus.proc2mem_command), 64'd0);
    tick();
    clear_inputs();
    mem_return(4'd5, 64'hBAD0_0000_0000_0005);
    @(negedge clock);
    check("sq_outstanding", 64'(bus.outstanding), 64'd1);
    tick();
    clear_inputs();
    @(negedge clock);
    check("sq_outstanding_free", 64'(bus.outstanding), 64'd0);
    tick();

    // A store with response 7 takes no entry, and a stray tag 7 gives nothing.
    bus.d_req_valid = 1'b1; bus.d_req_cmd = 2'd2; bus.d_req_addr = 'h400;
    bus.d_req_data = 64'hDEAD_BEEF_0123_4567;
    bus.mem2proc_response = 4'd7;
    @(negedge clock);
    check("st_d_grant", 64'(bus.d_req_grant), 64'd1);
    check("st_command", 64'(bus.proc2mem_command), 64'd2);
    check("st_data", bus.proc2mem_data, 64'hDEAD_BEEF_0123_4567);
    tick();
    clear_inputs();
    mem_return(4'd7, 64'hBAD0_0000_0000_0007);
    @(negedge clock);
    check("st_outstanding", 64'(bus.outstanding), 64'd0);
    tick();
    clear_inputs();
    @(negedge clock);
    check("st_outstanding_after", 64'(bus.outstanding), 64'd0);
    tick();

    // Response 0 for three cycles, so the load retries, then is granted.
    bus.d_req_valid = 1'b1; bus.d_req_cmd = 2'd1; bus.d_req_addr = 'h508;
    for (int i = 0; i < 3; i++) begin
      bus.mem2proc_response = 4'd0;
      @(negedge clock);
      check($sformatf("retry_no_grant_%0d", i), 64'(bus.d_req_grant), 64'd0);
      check($sformatf("retry_command_%0d", i), 64'(bus.proc2mem_command), 64'd1);
      tick();
    end
    bus.mem2proc_response = 4'd2;
    @(negedge clock);
    check("retry_grant", 64'(bus.d_req_grant), 64'd1);
    tick();
    clear_inputs();
    mem_return(4'd2, 64'h0000_0000_0000_0508);
    exp_q.push_back({1'b1, 64'h0000_0000_0000_0508});
    tick();

    // Tag 4 returns to fetch while data reallocates tag 4 in the same cycle.
    clear_inputs();
    bus.if_req_valid = 1'b1; bus.if_req_addr = 'h600;
    bus.mem2proc_response = 4'd4;
    tick();
    clear_inputs();
    mem_return(4'd4, 64'hF00D_0000_0000_0600);
    exp_q.push_back({1'b0, 64'hF00D_0000_0000_0600});
    bus.d_req_valid = 1'b1; bus.d_req_cmd = 2'd1; bus.d_req_addr = 'h608;
    bus.mem2proc_response = 4'd4;
    @(negedge clock);
    check("realloc_d_grant", 64'(bus.d_req_grant), 64'd1);
    check("realloc_outstanding_pre", 64'(bus.outstanding), 64'd1);
    tick();
    clear_inputs();
    mem_return(4'd4, 64'hF00D_0000_0000_0608);
    exp_q.push_back({1'b1, 64'hF00D_0000_0000_0608});
    @(negedge clock);
    check("realloc_outstanding", 64'(bus.outstanding), 64'd1);
    tick();
    clear_inputs();

    // Squash coincides with a fetch return: the return is delivered, and the
    // data entry is unaffected.
    bus.d_req_valid = 1'b1; bus.d_req_cmd = 2'd1; bus.d_req_addr = 'h700;
    bus.mem2proc_response = 4'd10;
    tick();
    clear_inputs();
    bus.if_req_valid = 1'b1; bus.if_req_addr = 'h708;
    bus.mem2proc_response = 4'd9;
    tick();
    clear_inputs();
    bus.if_squash = 1'b1;
    mem_return(4'd9, 64'h0000_0000_0000_0709);
    exp_q.push_back({1'b0, 64'h0000_0000_0000_0709});
    tick();
    clear_inputs();
    mem_return(4'd10, 64'h0000_0000_0000_070A);
    exp_q.push_back({1'b1, 64'h0000_0000_0000_070A});
    tick();
    clear_inputs();
    @(negedge clock);
    check("sqret_outstanding", 64'(bus.outstanding), 64'd0);
    tick();

    // A reset with a load in flight drops it, so a later return is ignored.
    bus.d_req_valid = 1'b1; bus.d_req_cmd = 2'd1; bus.d_req_addr = 'h780;
    bus.mem2proc_response = 4'd11;
    tick();
    clear_inputs();
    @(negedge clock);
    check("rstdrop_outstanding_pre", 64'(bus.outstanding), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_return(4'd11, 64'hBAD0_0000_0000_000B);
    @(negedge clock);
    check("rstdrop_outstanding", 64'(bus.outstanding), 64'd0);
    tick();
    clear_inputs();
    @(negedge clock);
    check("rstdrop_outstanding_after", 64'(bus.outstanding), 64'd0);
    tick();

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 2: the number of consecutive data grants allowed while a fetch request waits.
REQ-002 Signal clock, input, 1 bit: the clock; all state updates on its rising edge.
REQ-003 Signal reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Signal if_req_valid, input, 1 bit: fetch read request; held until granted or squashed.
REQ-005 Signal if_req_addr, input, `XLEN: fetch address, 8-byte aligned.
REQ-006 Signal if_squash, input, 1 bit: fetch redirect; invalidates fetch reads already in flight.
REQ-007 Signal if_req_grant, output, 1 bit: fetch request accepted by memory this cycle.
REQ-008 Signal if_resp_valid, output, 1 bit: fetch read data returning.
REQ-009 Signal if_resp_data, output, 64 bits: fetch read data.
REQ-010 Signal d_req_valid, input, 1 bit: data request; held until granted.
REQ-011 Signal d_req_cmd, input, 2 bits: BUS_LOAD=1 or BUS_STORE=2.
REQ-012 Signal d_req_addr, input, `XLEN: data address.
REQ-013 Signal d_req_data, input, 64 bits: store data.
REQ-014 Signal d_req_grant, output, 1 bit: data request accepted by memory this cycle.
REQ-015 Signal d_resp_valid, output, 1 bit: load data returning.
REQ-016 Signal d_resp_data, output, 64 bits: load data.
REQ-017 Signal proc2mem_command, output, 2 bits: BUS_NONE=0, BUS_LOAD=1 or BUS_STORE=2.
REQ-018 Signal proc2mem_addr, output, `XLEN: memory address.
REQ-019 Signal proc2mem_data, output, 64 bits: memory store data.
REQ-020 Signal mem2proc_response, input, 4 bits: tag assigned by memory; 0 means not accepted.
REQ-021 Signal mem2proc_data, input, 64 bits: returning data.
REQ-022 Signal mem2proc_tag, input, 4 bits: tag of returning data; 0 means none.
REQ-023 Signal outstanding, output, 5 bits: number of valid tag-table entries.

Function
REQ-024 Selection and command drive SHALL be combinational: at most one requester is driven onto proc2mem_* per cycle.
REQ-025 Default priority SHALL be data over fetch.
REQ-026 A starvation counter SHALL increment on each data grant made while if_req_valid=1.
REQ-027 The starvation counter SHALL clear on any fetch grant or in any cycle with if_req_valid=0.
REQ-028 When the starvation counter is at least STARVE_LIMIT, fetch SHALL have priority.
REQ-029 In a cycle with if_squash=1, fetch SHALL NOT be selected, and if_req_grant SHALL be 0.
REQ-030 A grant SHALL be asserted only for the selected requester and only when mem2proc_response!=0.
REQ-031 If mem2proc_response=0, no grant is asserted and the requester retries next cycle.
REQ-032 An accepted load (fetch or data) SHALL write tag-table entry [mem2proc_response] with valid=1, owner (0=fetch, 1=data) and discard=0.
REQ-033 An accepted store SHALL complete on acceptance: no table entry and no response.
REQ-034 When mem2proc_tag!=0 and the matching entry is valid, the arbiter SHALL in the same cycle:
- assert if_resp_valid or d_resp_valid according to owner, with data=mem2proc_data;
- suppress the response if discard=1;
- clear the entry.
REQ-035 A returning tag that matches an invalid entry SHALL be ignored, with no response and no state change.
REQ-036 if_squash=1 SHALL set discard on every valid fetch-owned entry; data entries are unaffected.
REQ-037 If the same tag returns and is reallocated in one cycle, the return SHALL be processed first and the new allocation SHALL remain valid afterwards.
REQ-038 If a fetch return and if_squash=1 coincide, the return SHALL be delivered.
REQ-039 outstanding SHALL equal the count of valid entries, updated each cycle as +1 for allocate and -1 for free (net 0 when both occur).
REQ-040 Fetch and data responses SHALL never both be asserted in one cycle.

Reset
REQ-041 While reset=1, the following SHALL hold:
- proc2mem_command=BUS_NONE;
- all grants and response valids 0;
- the tag table cleared;
- the starvation counter 0;
- outstanding 0.
REQ-042 Reset during in-flight loads SHALL drop them: later returns of those tags are ignored.

Verification
REQ-043 Both requesting loads, response=3 -> d_req_grant=1, if_req_grant=0, command=BUS_LOAD, entry 3 owner=data, outstanding=1.
REQ-044 Both requesting continuously, responses always nonzero, STARVE_LIMIT=2 -> grant order data, data, fetch, data, data, fetch.
REQ-045 Fetch load accepted with tag 5, if_squash pulsed, then mem2proc_tag=5 -> if_resp_valid stays 0 and outstanding returns to 0.
REQ-046 Data store, response=7 -> d_req_grant=1, proc2mem_data=d_req_data, outstanding unchanged, no response ever produced.
REQ-047 mem2proc_response=0 for 3 cycles with d_req_valid held -> no grant for those cycles, then granted on the first nonzero response.
REQ-048 Return of tag 4 plus reallocation of tag 4 in the same cycle -> old response delivered, entry 4 valid with new owner, outstanding unchanged.
